// File: rtl/merge_2.sv
`default_nettype none
// ============================================================================
//  Module   : merge_2
//  Purpose  : Two-input Avalon-ST packet merge, round-robin per packet,
//             registered output, optional per-port packet statistics
//             (enabled by defining MERGE_2_STATS_EN).
//  Revision : 1.0
// ============================================================================
module merge_2 #(
  parameter int DWIDTH = 512,
  parameter int EWIDTH = 6
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [DWIDTH-1:0] in0_data,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic              in0_sop,
  input  logic              in0_eop,
  input  logic [EWIDTH-1:0] in0_empty,

  input  logic [DWIDTH-1:0] in1_data,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic              in1_sop,
  input  logic              in1_eop,
  input  logic [EWIDTH-1:0] in1_empty,

  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic [EWIDTH-1:0] out_empty,
  output logic              out_channel,
  input  logic              out_almost_full,

  output logic [31:0]       stats_in0_pkt,
  output logic [31:0]       stats_in1_pkt,
  output logic [31:0]       stats_out_pkt,
  output logic [31:0]       stats_drop
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOCK0 = 2'd1;
  localparam logic [1:0] S_LOCK1 = 2'd2;

  logic [1:0] r_state;
  logic       r_last;

  logic w_adv;
  logic w_cand0, w_cand1;
  logic w_grant0, w_grant1;
  logic w_orphan0, w_orphan1;
  logic w_fwd0, w_fwd1;
  logic w_drop0, w_drop1;

  always_comb begin
    w_adv     = !out_valid || out_ready;
    w_cand0   = in0_valid && in0_sop && !out_almost_full;
    w_cand1   = in1_valid && in1_sop && !out_almost_full;
    // On a tie the port opposite the last-served one wins.
    w_grant0  = w_cand0 && (!w_cand1 || r_last);
    w_grant1  = w_cand1 && (!w_cand0 || !r_last);
    w_orphan0 = in0_valid && !in0_sop;
    w_orphan1 = in1_valid && !in1_sop;
  end

  always_comb begin
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          // Orphan drop ignores backpressure so stray beats never block a port.
          in0_ready = w_grant0 ? w_adv : w_orphan0;
          in1_ready = w_grant1 ? w_adv : w_orphan1;
        end
        S_LOCK0: in0_ready = w_adv;
        S_LOCK1: in1_ready = w_adv;
        default: begin
          in0_ready = 1'b0;
          in1_ready = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_fwd0  = in0_valid && in0_ready &&
              ((r_state == S_LOCK0) || ((r_state == S_IDLE) && in0_sop));
    w_fwd1  = in1_valid && in1_ready &&
              ((r_state == S_LOCK1) || ((r_state == S_IDLE) && in1_sop));
    w_drop0 = in0_valid && in0_ready && (r_state == S_IDLE) && !in0_sop;
    w_drop1 = in1_valid && in1_ready && (r_state == S_IDLE) && !in1_sop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fwd0 && !in0_eop)
            r_state <= S_LOCK0;
          else if (w_fwd1 && !in1_eop)
            r_state <= S_LOCK1;
        end
        S_LOCK0: if (w_fwd0 && in0_eop) r_state <= S_IDLE;
        S_LOCK1: if (w_fwd1 && in1_eop) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_fwd0 && in0_sop)
        r_last <= 1'b0;
      else if (w_fwd1 && in1_sop)
        r_last <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_data    <= '0;
      out_empty   <= '0;
      out_channel <= 1'b0;
    end else if (w_adv) begin
      out_valid <= w_fwd0 || w_fwd1;
      if (w_fwd0) begin
        out_data    <= in0_data;
        out_sop     <= in0_sop;
        out_eop     <= in0_eop;
        out_empty   <= in0_empty;
        out_channel <= 1'b0;
      end else if (w_fwd1) begin
        out_data    <= in1_data;
        out_sop     <= in1_sop;
        out_eop     <= in1_eop;
        out_empty   <= in1_empty;
        out_channel <= 1'b1;
      end
    end
  end

`ifdef MERGE_2_STATS_EN
  logic [31:0] r_in0_pkt;
  logic [31:0] r_in1_pkt;
  logic [31:0] r_out_pkt;
  logic [31:0] r_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in0_pkt <= '0;
      r_in1_pkt <= '0;
      r_out_pkt <= '0;
      r_drop    <= '0;
    end else begin
      if (w_fwd0 && in0_eop)
        r_in0_pkt <= r_in0_pkt + 32'd1;
      if (w_fwd1 && in1_eop)
        r_in1_pkt <= r_in1_pkt + 32'd1;
      if (out_valid && out_ready && out_eop)
        r_out_pkt <= r_out_pkt + 32'd1;
      r_drop <= r_drop + {31'd0, w_drop0} + {31'd0, w_drop1};
    end
  end

  assign stats_in0_pkt = r_in0_pkt;
  assign stats_in1_pkt = r_in1_pkt;
  assign stats_out_pkt = r_out_pkt;
  assign stats_drop    = r_drop;
`else
  logic w_unused_drop;
  assign w_unused_drop = w_drop0 ^ w_drop1;

  assign stats_in0_pkt = 32'd0;
  assign stats_in1_pkt = 32'd0;
  assign stats_out_pkt = 32'd0;
  assign stats_drop    = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_merge_2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_merge_2
//  Purpose  : Scoreboard bench for merge_2 (directed vectors, queue-based
//             drivers per input port, independent output monitor).
//  Revision : 1.0
// ============================================================================
module tb_merge_2;

  localparam int DW = 32;
  localparam int EW = 2;
`ifdef MERGE_2_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic          ch;
  } obeat_t;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in0_data, in1_data, out_data;
  logic          in0_valid, in0_ready, in0_sop, in0_eop;
  logic          in1_valid, in1_ready, in1_sop, in1_eop;
  logic [EW-1:0] in0_empty, in1_empty, out_empty;
  logic          out_valid, out_ready, out_sop, out_eop, out_channel;
  logic          out_almost_full;
  logic [31:0]   stats_in0_pkt, stats_in1_pkt, stats_out_pkt, stats_drop;

  merge_2 #(.DWIDTH(DW), .EWIDTH(EW)) dut (
    .clk(clk), .rst(rst),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in0_sop(in0_sop), .in0_eop(in0_eop), .in0_empty(in0_empty),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .in1_sop(in1_sop), .in1_eop(in1_eop), .in1_empty(in1_empty),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
    .out_channel(out_channel), .out_almost_full(out_almost_full),
    .stats_in0_pkt(stats_in0_pkt), .stats_in1_pkt(stats_in1_pkt),
    .stats_out_pkt(stats_out_pkt), .stats_drop(stats_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t  q0[$];
  beat_t  q1[$];
  obeat_t exp_q[$];
  int     hs_cyc[$];
  int     acc0_cyc[$];
  int     acc1_cyc[$];
  int     acc0 = 0;
  int     acc1 = 0;
  int     ncyc = 0;
  int     checks = 0;
  int     errors = 0;
  logic   rdy0_s = 1'b0;
  logic   rdy1_s = 1'b0;
  int     e_in0 = 0, e_in1 = 0, e_out = 0, e_drop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Queue one packet on a port; optionally append its beats to the expected stream.
  task automatic pkt(input int port, input logic [DW-1:0] base, input int n, input bit exp_it);
    beat_t  b;
    obeat_t o;
    for (int i = 0; i < n; i++) begin
      b.data  = base + DW'(i);
      b.sop   = (i == 0);
      b.eop   = (i == n - 1);
      b.empty = (i == n - 1) ? EW'(n % 4) : '0;
      if (port == 0) q0.push_back(b); else q1.push_back(b);
      if (exp_it) begin
        o = {b.data, b.sop, b.eop, b.empty, (port == 1)};
        exp_q.push_back(o);
      end
    end
  endtask

  task automatic orphan(input int port, input logic [DW-1:0] d, input logic eop);
    beat_t b;
    b.data  = d;
    b.sop   = 1'b0;
    b.eop   = eop;
    b.empty = '0;
    if (port == 0) q0.push_back(b); else q1.push_back(b);
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #2;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: exp=%0d q0=%0d q1=%0d left, required 0",
               name, exp_q.size(), q0.size(), q1.size());
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic chk_stats(input string name);
    @(negedge clk);
    chk({name, "_in0_pkt"}, stats_in0_pkt, STATS ? 32'(e_in0) : 32'd0);
    chk({name, "_in1_pkt"}, stats_in1_pkt, STATS ? 32'(e_in1) : 32'd0);
    chk({name, "_out_pkt"}, stats_out_pkt, STATS ? 32'(e_out) : 32'd0);
    chk({name, "_drop"},    stats_drop,    STATS ? 32'(e_drop) : 32'd0);
  endtask

  // Port drivers: a beat leaves its queue once it was accepted at the edge.
  initial begin : drv0
    beat_t b;
    in0_valid = 1'b0; in0_data = '0; in0_sop = 1'b0; in0_eop = 1'b0; in0_empty = '0;
    forever begin
      @(posedge clk);
      if (in0_valid && rdy0_s) begin
        b = q0.pop_front();
        acc0++;
        acc0_cyc.push_back(ncyc);
      end
      #1;
      if (q0.size() > 0) begin
        b = q0[0];
        in0_data = b.data; in0_sop = b.sop; in0_eop = b.eop; in0_empty = b.empty;
        in0_valid = 1'b1;
      end else begin
        in0_valid = 1'b0;
      end
    end
  end

  initial begin : drv1
    beat_t b;
    in1_valid = 1'b0; in1_data = '0; in1_sop = 1'b0; in1_eop = 1'b0; in1_empty = '0;
    forever begin
      @(posedge clk);
      if (in1_valid && rdy1_s) begin
        b = q1.pop_front();
        acc1++;
        acc1_cyc.push_back(ncyc);
      end
      #1;
      if (q1.size() > 0) begin
        b = q1[0];
        in1_data = b.data; in1_sop = b.sop; in1_eop = b.eop; in1_empty = b.empty;
        in1_valid = 1'b1;
      end else begin
        in1_valid = 1'b0;
      end
    end
  end

  initial begin : monitor
    obeat_t cur, saved, e;
    bit     held;
    held  = 1'b0;
    saved = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      rdy0_s = in0_ready;
      rdy1_s = in1_ready;
      cur = {out_data, out_sop, out_eop, out_empty, out_channel};
      if (held) begin
        checks++;
        if (cur !== saved) begin
          errors++;
          $display("FAIL stall_hold: got %h expected %h", cur, saved);
        end
      end
      if (!rst && out_valid && out_ready) begin
        hs_cyc.push_back(ncyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h expected no beat", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL out_beat: got data=%h sop=%b eop=%b empty=%0d ch=%b expected data=%h sop=%b eop=%b empty=%0d ch=%b",
                     cur.data, cur.sop, cur.eop, cur.empty, cur.ch,
                     e.data, e.sop, e.eop, e.empty, e.ch);
          end
        end
      end
      held  = out_valid && !out_ready && !rst;
      saved = cur;
    end
  end

  initial begin : stim
    int base, abase, target;
    rst = 1'b1;
    out_ready = 1'b1;
    out_almost_full = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sop_eop", {30'd0, out_sop, out_eop}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_channel", {31'd0, out_channel}, 32'd0);
    chk_stats("rst");

    // Both ports refill 2-beat packets: strict 0,1,0,1 with no gap.
    @(posedge clk); #2;
    base = hs_cyc.size();
    pkt(0, 32'h0000_0100, 2, 1);
    pkt(1, 32'h0000_1100, 2, 1);
    pkt(0, 32'h0000_0200, 2, 1);
    pkt(1, 32'h0000_1200, 2, 1);
    wait_idle("rr");
    if (hs_cyc.size() >= base + 8)
      chk("rr_no_bubble_span", 32'(hs_cyc[base+7] - hs_cyc[base]), 32'd7);
    else
      chk("rr_beat_count", 32'(hs_cyc.size() - base), 32'd8);
    e_in0 += 2; e_in1 += 2; e_out += 4;
    chk_stats("rr");

    // Single 3-beat packet, one-cycle latency.
    @(posedge clk); #2;
    base  = hs_cyc.size();
    abase = acc0_cyc.size();
    pkt(0, 32'h0000_2000, 3, 1);
    wait_idle("single");
    if (hs_cyc.size() > base && acc0_cyc.size() > abase)
      chk("single_latency", 32'(hs_cyc[base] - acc0_cyc[abase]), 32'd1);
    else
      chk("single_seen", 32'(hs_cyc.size() - base), 32'd3);
    e_in0 += 1; e_out += 1;
    chk_stats("single");

    // out_ready toggling during a 4-beat packet.
    @(posedge clk); #2;
    base = hs_cyc.size();
    pkt(0, 32'h0000_3000, 4, 1);
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #2;
      out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    wait_idle("toggle");
    if (hs_cyc.size() >= base + 4)
      chk("toggle_span", 32'(hs_cyc[base+3] - hs_cyc[base]), 32'd6);
    else
      chk("toggle_beat_count", 32'(hs_cyc.size() - base), 32'd4);
    e_in0 += 1; e_out += 1;
    chk_stats("toggle");

    // almost_full in IDLE blocks both packet starts; port 1 then wins the tie.
    @(posedge clk); #2;
    out_almost_full = 1'b1;
    pkt(1, 32'h0000_4100, 1, 1);
    pkt(0, 32'h0000_4000, 1, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("afull_ready", {30'd0, in0_ready, in1_ready}, 32'd0);
    chk("afull_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #2;
    out_almost_full = 1'b0;
    wait_idle("afull");
    e_in0 += 1; e_in1 += 1; e_out += 2;
    chk_stats("afull");

    // almost_full raised mid-packet on LOCK1 does not stop the packet.
    target = acc1 + 1;
    pkt(1, 32'h0000_5000, 4, 1);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      if (acc1 >= target) break;
    end
    out_almost_full = 1'b1;
    wait_idle("lock1_afull");
    out_almost_full = 1'b0;
    e_in1 += 1; e_out += 1;
    chk_stats("lock1_afull");

    // Orphans on port 1, then one orphan on each port in the same cycle.
    orphan(1, 32'h0000_6000, 1'b0);
    orphan(1, 32'h0000_6001, 1'b1);
    wait_idle("orphan1");
    e_drop += 2;
    chk_stats("orphan1");
    chk("orphan_out_valid", {31'd0, out_valid}, 32'd0);
    orphan(0, 32'h0000_7000, 1'b0);
    orphan(1, 32'h0000_7100, 1'b0);
    wait_idle("orphan2");
    e_drop += 2;
    chk_stats("orphan2");

    // Reset while the 2nd beat of a 4-beat packet sits in the output register.
    target = acc0 + 2;
    pkt(0, 32'h0000_8000, 4, 0);
    begin
      obeat_t o;
      o = {32'h0000_8000, 1'b1, 1'b0, 2'd0, 1'b0};
      exp_q.push_back(o);
    end
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      if (acc0 >= target) break;
    end
    rst = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_pkt", stats_out_pkt, 32'd0);
    chk("midrst_drop", stats_drop, 32'd0);
    chk("midrst_in1_pkt", stats_in1_pkt, 32'd0);
    wait_idle("midrst");
    chk("midrst_orphan_drop", stats_drop, STATS ? 32'd2 : 32'd0);
    chk("midrst_out_pkt_after", stats_out_pkt, 32'd0);
    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
